branch_ctrl: RTL and testbench

- Branch resolution and prediction controller for the pipelined RV32I core.
- Sits in EX next to the branch comparator. It drives the comparator's unsigned-select input and turns the comparator's less/equal flags into a taken decision.
- It also predicts conditional branches in IF with a direct-mapped table of 2-bit saturating counters (BHT), issues a registered flush/redirect on mispredict, and keeps branch/mispredict counters.

---
 rtl/branch_ctrl.sv | 69 ++++++
 tb/tb_branch_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// branch_ctrl: EX branch resolution, 2-bit BHT prediction, registered mispredict flush and counters
module branch_ctrl #(
    parameter int BHT_DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_if_pc,
    output logic        o_if_pred_taken,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_br,
    input  logic [31:0] i_ex_pc,
    input  logic [2:0]  i_ex_funct3,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_target,
    output logic        o_br_un,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_ex_taken,
    output logic        o_flush,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_mispred_cnt
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    logic [1:0]       bht_q [BHT_DEPTH];
    logic             flush_q;
    logic [31:0]      redirect_q, redirect_d, br_cnt_q, mis_cnt_q;
    logic             legal, res, mis;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       ctr, ctr_d;
    logic             unused_if;
    assign unused_if = ^{i_if_pc[31:IDX_W+2], i_if_pc[1:0]};
    assign o_if_pred_taken = bht_q[i_if_pc[IDX_W+1:2]][1];
    assign o_flush = flush_q;
    assign o_redirect_pc = redirect_q;
    assign o_br_cnt = br_cnt_q;
    assign o_mispred_cnt = mis_cnt_q;
    // funct3[0] inverts the base condition; funct3[2] selects less vs equal
    always_comb begin
        legal = i_ex_funct3[2] | ~i_ex_funct3[1];
        o_br_un = i_ex_is_br & (i_ex_funct3[2:1] == 2'b11);
        o_ex_taken = i_ex_is_br & legal &
            (i_ex_funct3[2] ? (i_br_less ^ i_ex_funct3[0]) : (i_br_equal ^ i_ex_funct3[0]));
        res = i_ex_valid & i_ex_is_br & legal & ~flush_q;
        mis = res & (o_ex_taken != i_ex_pred_taken);
        ex_idx = i_ex_pc[IDX_W+1:2];
        ctr = bht_q[ex_idx];
        ctr_d = o_ex_taken ? ((ctr == 2'b11) ? ctr : ctr + 2'd1)
                           : ((ctr == 2'b00) ? ctr : ctr - 2'd1);
        redirect_d = mis ? (o_ex_taken ? i_ex_target : i_ex_pc + 32'd4) : redirect_q;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            flush_q <= 1'b0;
            redirect_q <= '0;
            br_cnt_q <= '0;
            mis_cnt_q <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
        end else begin
            flush_q <= mis;
            redirect_q <= redirect_d;
            if (res) begin
                bht_q[ex_idx] <= ctr_d;
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (mis) mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed self-checking bench for branch_ctrl
module tb_branch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred;
    logic        ex_valid, ex_is_br, ex_pred, br_un, br_less, br_equal, ex_taken, flush;
    logic [31:0] ex_pc, ex_target, redirect_pc, br_cnt, mis_cnt;
    logic [2:0]  ex_f3;
    int          n_cmp = 0;
    int          n_err = 0;

    branch_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_if_pc(if_pc), .o_if_pred_taken(if_pred),
        .i_ex_valid(ex_valid), .i_ex_is_br(ex_is_br), .i_ex_pc(ex_pc), .i_ex_funct3(ex_f3),
        .i_ex_pred_taken(ex_pred), .i_ex_target(ex_target), .o_br_un(br_un),
        .i_br_less(br_less), .i_br_equal(br_equal), .o_ex_taken(ex_taken),
        .o_flush(flush), .o_redirect_pc(redirect_pc), .o_br_cnt(br_cnt), .o_mispred_cnt(mis_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic [31:0] pc, input logic [2:0] f3, input logic eq, input logic lt,
                      input logic pred, input logic [31:0] tgt);
        ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = pc; ex_f3 = f3;
        br_equal = eq; br_less = lt; ex_pred = pred; ex_target = tgt;
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_is_br = 1'b0; br_equal = 1'b0; br_less = 1'b0; ex_pred = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; if_pc = '0; ex_pc = '0; ex_f3 = '0; ex_target = '0;
        idle();
        step(); step();
        rst = 1'b0;
        check("rst_flush", flush, 0);
        check("rst_redirect", redirect_pc, 0);
        check("rst_br_cnt", br_cnt, 0);
        check("rst_mis_cnt", mis_cnt, 0);
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i * 4); #1;
            check($sformatf("rst_pred_%0d", i), if_pred, 0);
        end

        br(32'h100, 3'b000, 1, 0, 0, 32'h180);
        check("beq_taken", ex_taken, 1);
        check("beq_un", br_un, 0);
        step(); idle();
        check("beq_flush", flush, 1);
        check("beq_redirect", redirect_pc, 32'h180);
        check("beq_mis_cnt", mis_cnt, 1);
        check("beq_br_cnt", br_cnt, 1);
        if_pc = 32'h100; #1;
        check("beq_pred_after", if_pred, 1);
        step();
        check("flush_pulse", flush, 0);
        check("redirect_hold", redirect_pc, 32'h180);

        br(32'h204, 3'b110, 0, 1, 1, 32'h300);
        check("bltu_un", br_un, 1);
        check("bltu_taken", ex_taken, 1);
        step();
        check("bltu_noflush", flush, 0);
        check("bltu_br_cnt", br_cnt, 2);
        check("bltu_mis_cnt", mis_cnt, 1);

        br(32'h208, 3'b101, 0, 1, 0, 32'h300);
        check("bge_un", br_un, 0);
        check("bge_taken", ex_taken, 0);
        step();
        check("bge_br_cnt", br_cnt, 3);
        check("bge_noflush", flush, 0);

        br(32'hFFFF_FFFC, 3'b000, 0, 0, 1, 32'h40);
        check("wrap_taken", ex_taken, 0);
        step(); idle();
        check("wrap_flush", flush, 1);
        check("wrap_redirect", redirect_pc, 32'h0);
        check("wrap_mis_cnt", mis_cnt, 2);
        step();

        for (int i = 0; i < 4; i++) begin
            br(32'h10C, 3'b000, 1, 0, 1, 32'h400);
            step();
        end
        idle();
        if_pc = 32'h10C; #1;
        check("sat_hi_pred", if_pred, 1);
        check("sat_br_cnt", br_cnt, 8);
        br(32'h10C, 3'b000, 0, 0, 0, 32'h400); step(); idle();
        check("dec1_pred", if_pred, 1);
        br(32'h10C, 3'b000, 0, 0, 0, 32'h400); step(); idle();
        check("dec2_pred", if_pred, 0);
        br(32'h10C, 3'b000, 0, 0, 0, 32'h400); step();
        br(32'h10C, 3'b000, 0, 0, 0, 32'h400); step();
        br(32'h10C, 3'b000, 1, 0, 1, 32'h400); step(); idle();
        check("sat_lo_pred", if_pred, 0);
        check("sat_lo_br_cnt", br_cnt, 13);
        check("sat_lo_mis_cnt", mis_cnt, 2);

        br(32'h110, 3'b000, 1, 0, 0, 32'h500);
        step();
        check("ign_flush", flush, 1);
        br(32'h114, 3'b000, 1, 0, 0, 32'h600);
        step(); idle();
        check("ign_noflush", flush, 0);
        check("ign_br_cnt", br_cnt, 14);
        check("ign_mis_cnt", mis_cnt, 3);
        check("ign_redirect", redirect_pc, 32'h500);
        if_pc = 32'h114; #1;
        check("ign_pred", if_pred, 0);

        br(32'h11C, 3'b010, 1, 1, 1, 32'h700);
        check("illegal_taken", ex_taken, 0);
        step(); idle();
        check("illegal_noflush", flush, 0);
        check("illegal_br_cnt", br_cnt, 14);

        br(32'h118, 3'b000, 1, 0, 0, 32'h800);
        rst = 1'b1;
        step(); idle();
        rst = 1'b0;
        check("rstbr_flush", flush, 0);
        check("rstbr_br_cnt", br_cnt, 0);
        check("rstbr_mis_cnt", mis_cnt, 0);
        if_pc = 32'h118; #1;
        check("rstbr_pred", if_pred, 0);
        if_pc = 32'h100; #1;
        check("rstbr_pred_old", if_pred, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
